// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e     : E-stage operation encoding driven onto md_op
//   - MD_CNT_W    : width of the busy counter
//   - MD_INT_MIN  : most negative 32-bit signed value
//   - md_is_start : true for the ops that launch a multi-cycle operation
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   localparam int unsigned MD_CNT_W   = 4;
   localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

   function automatic logic md_is_start(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
// Produces the full 64-bit {hi, lo} result for the operation on op; the controller
// latches it in the start cycle and commits it later.
//   op     in  3   operation (md_op_e encoding, already sanitised)
//   a      in  32  rs operand (dividend / multiplicand)
//   b      in  32  rt operand (divisor / multiplier)
//   result out 64  {hi, lo}: product, or {remainder, quotient}
//   valid  out 1   0 for a divide by zero (result must not be committed)
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        valid
);

   logic        sgn_div;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic [31:0] dvs_safe;
   logic [31:0] quo_mag;
   logic [31:0] rem_mag;
   logic [31:0] quo;
   logic [31:0] rem;

   // One unsigned divider serves both DIV and DIVU: signed division works on
   // magnitudes and re-applies the signs afterwards. INT_MIN / -1 falls out
   // naturally: |INT_MIN| = 0x80000000 as unsigned, and the quotient keeps that
   // bit pattern because both operand signs match.
   always_comb begin
      sgn_div  = (op == MD_DIV);
      dvd_mag  = (sgn_div && a[31]) ? (~a + 32'd1) : a;
      dvs_mag  = (sgn_div && b[31]) ? (~b + 32'd1) : b;
      // Keep the divider defined for b == 0; the result is flagged invalid anyway.
      dvs_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
      quo_mag  = dvd_mag / dvs_safe;
      rem_mag  = dvd_mag % dvs_safe;
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      quo      = (sgn_div && (a[31] ^ b[31])) ? (~quo_mag + 32'd1) : quo_mag;
      rem      = (sgn_div && a[31]) ? (~rem_mag + 32'd1) : rem_mag;
   end

   always_comb begin
      result = '0;
      valid  = 1'b1;
      case (op)
         MD_MULT: begin
            // Low 64 bits of the product of sign-extended operands equal the
            // signed 64-bit product.
            result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         end
         MD_MULTU: begin
            result = {32'd0, a} * {32'd0, b};
         end
         MD_DIV, MD_DIVU: begin
            result = {rem, quo};
            valid  = (b != 32'd0);
         end
         default: begin
            result = '0;
            valid  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller for the E stage.
// Owns HI/LO, sequences MULT/MULTU/DIV/DIVU through a busy counter, applies
// MTHI/MTLO and requests a stall while a D-stage mult/div-class instruction
// has to wait.
//   clk       in  1   system clock, rising edge
//   reset_n   in  1   asynchronous active-low reset
//   md_op     in  3   E-stage operation (md_op_e); codes above MD_MTLO act as MD_NONE
//   src_a     in  32  E-stage rs value
//   src_b     in  32  E-stage rt value
//   d_is_md   in  1   D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
//   md_cancel in  1   flush: drop the in-flight op and any same-cycle op
//                     (present only when MD_CANCEL_EN is defined)
//   md_busy   out 1   operation in flight
//   md_stall  out 1   stall request to the hazard unit
//   hi_out    out 32  HI register
//   lo_out    out 32  LO register
// Build option: define MD_CANCEL_EN to add md_cancel.
module md_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_is_md,
`ifdef MD_CANCEL_EN
   input  logic        md_cancel,
`endif
   output logic        md_busy,
   output logic        md_stall,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam logic [MD_CNT_W-1:0] MulCnt = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DivCnt = MD_CNT_W'(DIV_CYCLES);
   localparam logic [MD_CNT_W-1:0] CntOne = MD_CNT_W'(1);

   logic [2:0]          op;
   logic                start;
   logic                is_div;
   logic                cancel;
   logic                busy;
   logic [63:0]         ar_result;
   logic                ar_valid;

   logic [MD_CNT_W-1:0] cnt_q;
   logic [31:0]         hi_q;
   logic [31:0]         lo_q;
   logic [31:0]         pend_hi_q;
   logic [31:0]         pend_lo_q;

`ifdef MD_CANCEL_EN
   assign cancel = md_cancel;
`else
   assign cancel = 1'b0;
`endif

   always_comb begin
      op     = (md_op > MD_MTLO) ? MD_NONE : md_op;
      start  = md_is_start(op);
      is_div = (op == MD_DIV) || (op == MD_DIVU);
      busy   = (cnt_q != '0);
   end

   md_arith u_arith (
      .op     (op),
      .a      (src_a),
      .b      (src_b),
      .result (ar_result),
      .valid  (ar_valid)
   );

   // Priority: cancel > in-flight countdown > start > MTHI/MTLO.
   // While busy every new op is ignored, so HI/LO cannot change under a
   // pending result; a divide by zero therefore just pends the current HI/LO
   // and its commit is a no-op.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else if (cancel) begin
         cnt_q <= '0;
      end else if (busy) begin
         cnt_q <= cnt_q - CntOne;
         if (cnt_q == CntOne) begin
            hi_q <= pend_hi_q;
            lo_q <= pend_lo_q;
         end
      end else if (start) begin
         cnt_q <= is_div ? DivCnt : MulCnt;
         if (ar_valid) begin
            pend_hi_q <= ar_result[63:32];
            pend_lo_q <= ar_result[31:0];
         end else begin
            pend_hi_q <= hi_q;
            pend_lo_q <= lo_q;
         end
      end else if (op == MD_MTHI) begin
         hi_q <= src_a;
      end else if (op == MD_MTLO) begin
         lo_q <= src_a;
      end
   end

   assign md_busy  = busy;
   assign md_stall = d_is_md & (busy | start);
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the pipelined MIPS core; sits in the E stage beside the ALU.
- Owns HI/LO, sequences MULT/MULTU/DIV/DIVU with a busy counter, and applies MTHI/MTLO.
- Raises a stall request so the hazard logic can drop the PC/IF-ID enable while a D-stage mult/div-class instruction must wait.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- md_op  in  3  E-stage operation code (MD_* encoding from package); MD_NONE = idle
- src_a  in  32  E-stage rs value (forwarded)
- src_b  in  32  E-stage rt value (forwarded)
- d_is_md  in  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
- md_busy  out  1  operation in flight
- md_stall  out  1  stall request to hazard unit
- hi_out  out  32  current HI (MFHI source)
- lo_out  out  32  current LO (MFLO source)

Behaviour:
- Reset (async, reset_n=0): HI=0, LO=0, counter=0, pending regs=0, md_busy=0, md_stall=0 (while d_is_md=0).
- Start ops (MULT/MULTU/DIV/DIVU), md_op sampled in cycle T with md_busy=0:
  - At the T edge, the full result is computed and latched into pending_hi/pending_lo.
  - Counter is loaded with N (MULT_CYCLES or DIV_CYCLES).
- md_busy = (counter != 0): high for cycles T+1 .. T+N.
- Commit: on the edge where the counter goes 1->0, pending_hi/pending_lo are copied to HI/LO. The new values are visible from T+N+1, the same cycle md_busy falls.
- Start op while md_busy=1: ignored; counter, pending regs, HI and LO are unchanged. Hazard logic prevents this; the bench checks it anyway.
- MTHI/MTLO with md_busy=0: write src_a to HI/LO at the T edge; visible at T+1; no busy.
- MTHI/MTLO with md_busy=1: ignored.
- Arithmetic:
  - MULT: signed 64-bit product, HI=[63:32], LO=[31:0].
  - MULTU: same as MULT, unsigned.
  - DIV: signed; quotient truncates toward zero; remainder takes the sign of the dividend; LO=quotient, HI=remainder.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (src_b=0, DIV or DIVU): counter still runs DIV_CYCLES; commit leaves HI/LO unchanged.
- md_stall = d_is_md & (md_busy | md_op is a start op). Purely combinational from the registered counter and the E-stage md_op.
- hi_out/lo_out come directly from the HI/LO registers. There is no bypass of pending values.
- Reset asserted mid-operation: everything clears immediately and the pending result is lost.
- md_op values above MD_MTLO are treated as MD_NONE.

Optional Feature:
- Macro MD_CANCEL_EN.
- When defined: adds input port md_cancel (1 bit, exception/interrupt flush).
  - md_cancel=1 at an edge clears the counter without commit; HI/LO keep their old values.
  - md_cancel has priority over a same-cycle start or MTHI/MTLO, which is also suppressed.
  - md_busy is 0 the next cycle.
- When undefined: no port; every started operation always commits.

Decomposition:
- Shared package md_pkg holds:
  - op encoding: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6
  - counter width constant MD_CNT_W=4
  - helper constant MD_INT_MIN=32'h80000000
- One natural sub-module, md_arith: combinational 64-bit result {hi,lo} from op/src_a/src_b, including the div-by-zero valid flag.
- md_ctrl keeps the counter, pending regs, HI/LO and stall logic.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> md_busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 17/5 -> busy 10 cycles; then LO=3, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTLO 0x12345678 then DIV x/0 -> LO stays 0x12345678 after 10 busy cycles; MTHI issued during busy is ignored.
- d_is_md=1 held from the start cycle -> md_stall=1 in the start cycle and all busy cycles, 0 in the commit-visible cycle; d_is_md=0 -> md_stall=0 throughout.
- Start MULT 2*3, then pull reset_n low in busy cycle 2 -> HI=LO=0, md_busy=0 immediately; no commit after release.
- With MD_CANCEL_EN: MTLO 7, then MULT 4*4, assert md_cancel in busy cycle 3 -> md_busy=0 next cycle, LO=7 unchanged; DIV 0x80000000/0xFFFFFFFF without cancel -> LO=0x80000000, HI=0.
